// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: converts SPI byte frames from spi_slave into register-bus
// read/write cycles. The first byte of a frame is the command; each later byte
// is a data byte at an auto-incrementing address. For reads, the bridge
// prefetches the data so it is already loaded when the host clocks the byte out.
module spi_reg_bridge #(
  parameter int         ADDR_W  = 7,
  parameter int         TIMEOUT = 255,
  parameter logic [5:0] ID_BITS = 6'h15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss_i,
  input  logic              byte_done_i,
  input  logic [7:0]        rx_byte_i,
  output logic [7:0]        tx_byte_o,
  output logic              tx_update_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [7:0]        reg_wdata_o,
  output logic              reg_we_o,
  output logic              reg_re_o,
  input  logic [7:0]        reg_rdata_i,
  input  logic              reg_ack_i,
  input  logic              err_clr_i,
  output logic              err_ovr_o,
  output logic              err_tmo_o,
  output logic              busy_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CMD     = 3'd1;
  localparam logic [2:0] S_WR_WAIT = 3'd2;
  localparam logic [2:0] S_WR_BUS  = 3'd3;
  localparam logic [2:0] S_RD_BUS  = 3'd4;
  localparam logic [2:0] S_RD_WAIT = 3'd5;
  localparam logic [2:0] S_DRAIN   = 3'd6;

  logic              ss_meta_q, ss_sync_q, ss_prev_q;
  logic              ss_fall, ss_high;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              tx_upd_q, tx_upd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovr_pend_q, ovr_pend_d;   // overrun seen during this bus cycle
  logic              ss_rose_q, ss_rose_d;     // ss went high during this bus cycle
  logic              err_ovr_q, err_ovr_d;
  logic              err_tmo_q, err_tmo_d;
  logic              ovr_set, tmo_set;
  logic              bus_end, bus_tmo, frame_over;

  // Two-flop synchroniser for the raw slave select plus one delay stage for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_meta_q <= 1'b1;
      ss_sync_q <= 1'b1;
      ss_prev_q <= 1'b1;
    end else begin
      ss_meta_q <= ss_i;
      ss_sync_q <= ss_meta_q;
      ss_prev_q <= ss_sync_q;
    end
  end

  assign ss_fall = ss_prev_q & ~ss_sync_q;
  assign ss_high = ss_sync_q;

  // A bus cycle ends on ack or when the request has been held for TIMEOUT cycles.
  assign bus_tmo    = ~reg_ack_i && (cnt_q == CW'(TIMEOUT - 1));
  assign bus_end    = reg_ack_i || bus_tmo;
  // Once ss has gone high during a bus cycle, the frame is finished for us.
  assign frame_over = ss_rose_q | ss_high;

  // Next-state and datapath decode for the transaction FSM.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    re_d       = re_q;
    tx_byte_d  = tx_byte_q;
    tx_upd_d   = 1'b0;
    cnt_d      = cnt_q;
    ovr_pend_d = ovr_pend_q;
    ss_rose_d  = ss_rose_q;
    ovr_set    = 1'b0;
    tmo_set    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Status byte is kept current so the host sees it during the command byte.
        tx_byte_d  = {err_ovr_q, err_tmo_q, ID_BITS};
        ovr_pend_d = 1'b0;
        ss_rose_d  = 1'b0;
        if (ss_fall) state_d = S_CMD;
      end

      S_CMD: begin
        if (ss_high) begin
          state_d = S_IDLE;
        end else if (byte_done_i) begin
          addr_d = rx_byte_i[ADDR_W-1:0];
          if (rx_byte_i[7]) begin
            re_d    = 1'b1;
            cnt_d   = '0;
            state_d = S_RD_BUS;
          end else begin
            state_d = S_WR_WAIT;
          end
        end
      end

      S_WR_WAIT: begin
        if (ss_high) begin
          state_d = S_IDLE;
        end else if (byte_done_i) begin
          wdata_d = rx_byte_i;
          we_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_WR_BUS;
        end
      end

      S_RD_WAIT: begin
        // The mosi byte is a dummy; its arrival means the prefetched byte was consumed.
        if (ss_high) begin
          state_d = S_IDLE;
        end else if (byte_done_i) begin
          re_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_RD_BUS;
        end
      end

      S_WR_BUS, S_RD_BUS: begin
        if (byte_done_i) begin
          ovr_set    = 1'b1;
          ovr_pend_d = 1'b1;
        end
        if (ss_high) ss_rose_d = 1'b1;

        if (bus_end) begin
          we_d = 1'b0;
          re_d = 1'b0;
          if (reg_ack_i) begin
            addr_d = addr_q + 1'b1;
            // No point loading the shifter once the host has ended the frame.
            if (state_q == S_RD_BUS && !frame_over) begin
              tx_byte_d = reg_rdata_i;
              tx_upd_d  = 1'b1;
            end
          end else begin
            tmo_set = 1'b1;
          end

          if (ss_high)
            state_d = S_IDLE;
          else if (bus_tmo || ovr_pend_q || byte_done_i || ss_rose_q)
            state_d = S_DRAIN;   // error, or ss re-fell: skip rest of this frame
          else
            state_d = (state_q == S_WR_BUS) ? S_WR_WAIT : S_RD_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DRAIN: begin
        if (ss_high) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Sticky error flags; a new error in the same cycle as err_clr stays set.
  always_comb begin
    err_ovr_d = (err_ovr_q & ~err_clr_i) | ovr_set;
    err_tmo_d = (err_tmo_q & ~err_clr_i) | tmo_set;
  end

  // State registers; reset drops any outstanding request immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      tx_byte_q  <= '0;
      tx_upd_q   <= 1'b0;
      cnt_q      <= '0;
      ovr_pend_q <= 1'b0;
      ss_rose_q  <= 1'b0;
      err_ovr_q  <= 1'b0;
      err_tmo_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      re_q       <= re_d;
      tx_byte_q  <= tx_byte_d;
      tx_upd_q   <= tx_upd_d;
      cnt_q      <= cnt_d;
      ovr_pend_q <= ovr_pend_d;
      ss_rose_q  <= ss_rose_d;
      err_ovr_q  <= err_ovr_d;
      err_tmo_q  <= err_tmo_d;
    end
  end

  assign tx_byte_o   = tx_byte_q;
  assign tx_update_o = tx_upd_q;
  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = wdata_q;
  assign reg_we_o    = we_q;
  assign reg_re_o    = re_q;
  assign err_ovr_o   = err_ovr_q;
  assign err_tmo_o   = err_tmo_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: drives SPI byte frames, models the register bus
// responder, and scores completed bus cycles and tx_update bytes against queues.
module tb_spi_reg_bridge;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ss = 1'b1;
  logic       byte_done = 1'b0;
  logic [7:0] rx_byte = '0;
  logic [7:0] tx_byte;
  logic       tx_update;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we, reg_re;
  logic [7:0] reg_rdata = '0;
  logic       reg_ack = 1'b0;
  logic       err_clr = 1'b0;
  logic       err_ovr, err_tmo, busy;

  typedef struct packed {
    logic       we;
    logic [6:0] addr;
    logic [7:0] data;
  } txn_t;

  txn_t       exp_bus[$];
  logic [7:0] exp_tx[$];
  logic [7:0] rd_data[$];
  txn_t       mon_t;

  int n_chk = 0;
  int n_bad = 0;
  int ack_dly = 2;
  bit ack_en = 1'b1;
  int wait_n = 0;
  int re_cycles = 0;

  spi_reg_bridge #(.ADDR_W(7), .TIMEOUT(255), .ID_BITS(6'h15)) dut (
    .clk(clk), .rst(rst), .ss_i(ss), .byte_done_i(byte_done), .rx_byte_i(rx_byte),
    .tx_byte_o(tx_byte), .tx_update_o(tx_update), .reg_addr_o(reg_addr),
    .reg_wdata_o(reg_wdata), .reg_we_o(reg_we), .reg_re_o(reg_re),
    .reg_rdata_i(reg_rdata), .reg_ack_i(reg_ack), .err_clr_i(err_clr),
    .err_ovr_o(err_ovr), .err_tmo_o(err_tmo), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Register-bus responder: ack after ack_dly extra cycles of an asserted request.
  initial forever begin
    @(posedge clk); #1;
    reg_ack = 1'b0;
    if ((reg_we || reg_re) && ack_en && !rst) begin
      if (wait_n >= ack_dly) begin
        reg_ack = 1'b1;
        if (reg_re) reg_rdata = (rd_data.size() > 0) ? rd_data.pop_front() : 8'hEE;
        wait_n = 0;
      end else begin
        wait_n++;
      end
    end else begin
      wait_n = 0;
    end
  end

  // Monitor: score completed bus cycles and tx_update loads.
  always @(negedge clk) begin
    if (!rst && reg_ack && (reg_we || reg_re)) begin
      if (exp_bus.size() == 0) chk("bus_unexpected", 1, 0);
      else begin
        mon_t = exp_bus.pop_front();
        chk("bus_kind", reg_we, mon_t.we);
        chk("bus_addr", reg_addr, mon_t.addr);
        if (mon_t.we) chk("bus_wdata", reg_wdata, mon_t.data);
      end
    end
    if (tx_update) begin
      if (exp_tx.size() == 0) chk("tx_unexpected", 1, 0);
      else chk("tx_byte", tx_byte, exp_tx.pop_front());
    end
    if (reg_re) re_cycles++;
  end

  task automatic frame_start();
    @(posedge clk); #1 ss = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic frame_end();
    @(posedge clk); #1 ss = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk); #1;
    byte_done = 1'b1;
    rx_byte   = b;
    @(posedge clk); #1;
    byte_done = 1'b0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
  endtask

  task automatic wait_req_low(input string tag, input int lim);
    int n = 0;
    while ((reg_we || reg_re) && n < lim) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, (n < lim), 1);
  endtask

  task automatic push_wr(input logic [6:0] a, input logic [7:0] d);
    exp_bus.push_back('{we: 1'b1, addr: a, data: d});
  endtask

  task automatic push_rd(input logic [6:0] a, input logic [7:0] d);
    exp_bus.push_back('{we: 1'b0, addr: a, data: 8'h00});
    rd_data.push_back(d);
    exp_tx.push_back(d);
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic queues_empty(input string tag);
    chk({tag, "_busq"}, exp_bus.size(), 0);
    chk({tag, "_txq"}, exp_tx.size(), 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_byte", tx_byte, 8'h00);
    chk("rst_tx_upd", tx_update, 0);
    chk("rst_we", reg_we, 0);
    chk("rst_re", reg_re, 0);
    chk("rst_addr", reg_addr, 0);
    chk("rst_wdata", reg_wdata, 0);
    chk("rst_errs", {err_ovr, err_tmo}, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_status", tx_byte, 8'h15);

    // 1: write frame
    ack_dly = 2;
    push_wr(7'h05, 8'hA1);
    push_wr(7'h06, 8'hB2);
    frame_start();
    chk("t1_busy", busy, 1);
    send_byte(8'h05, 12);
    send_byte(8'hA1, 12);
    send_byte(8'hB2, 12);
    frame_end();
    chk("t1_addr", reg_addr, 7'h07);
    chk("t1_errs", {err_ovr, err_tmo}, 0);
    chk("t1_busy", busy, 0);
    queues_empty("t1");

    // 2: read frame with prefetch (the last dummy byte prefetches one more)
    ack_dly = 1;
    push_rd(7'h05, 8'h3C);
    push_rd(7'h06, 8'h4D);
    push_rd(7'h07, 8'h5E);
    frame_start();
    send_byte(8'h85, 12);
    send_byte(8'h00, 12);
    send_byte(8'h00, 12);
    frame_end();
    chk("t2_errs", {err_ovr, err_tmo}, 0);
    queues_empty("t2");

    // 3: address wrap
    ack_dly = 0;
    push_wr(7'h7F, 8'h11);
    push_wr(7'h00, 8'h22);
    frame_start();
    send_byte(8'h7F, 12);
    send_byte(8'h11, 12);
    send_byte(8'h22, 12);
    frame_end();
    chk("t3_addr", reg_addr, 7'h01);
    queues_empty("t3");

    // 4: read timeout
    ack_en = 1'b0;
    re_cycles = 0;
    frame_start();
    send_byte(8'h90, 0);
    wait_req_low("t4_req_drop", 400);
    @(posedge clk); #1;
    chk("t4_re_cycles", re_cycles, 255);
    chk("t4_err_tmo", err_tmo, 1);
    chk("t4_busy_drain", busy, 1);
    send_byte(8'h99, 12);
    chk("t4_re_ignored", re_cycles, 255);
    chk("t4_we_ignored", reg_we, 0);
    frame_end();
    chk("t4_busy", busy, 0);
    chk("t4_status", tx_byte, 8'h55);
    pulse_clr();
    chk("t4_status_clr", tx_byte, 8'h15);
    chk("t4_err_tmo_clr", err_tmo, 0);
    ack_en = 1'b1;
    queues_empty("t4");

    // 5: overrun while write pending
    ack_dly = 4;
    push_wr(7'h20, 8'hAA);
    frame_start();
    send_byte(8'h20, 12);
    send_byte(8'hAA, 2);
    send_byte(8'hBB, 12);
    chk("t5_err_ovr", err_ovr, 1);
    chk("t5_busy_drain", busy, 1);
    send_byte(8'hCC, 12);
    chk("t5_we_drain", reg_we, 0);
    frame_end();
    chk("t5_busy", busy, 0);
    chk("t5_status", tx_byte, 8'h95);
    pulse_clr();
    chk("t5_err_ovr_clr", err_ovr, 0);
    queues_empty("t5");

    // 6: ss rises during RD_BUS; cycle completes, no tx_update
    ack_dly = 6;
    exp_bus.push_back('{we: 1'b0, addr: 7'h30, data: 8'h00});
    rd_data.push_back(8'h77);
    frame_start();
    send_byte(8'hB0, 0);
    chk("t6_re", reg_re, 1);
    ss = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_busy_pend", busy, 1);
    chk("t6_re_held", reg_re, 1);
    wait_req_low("t6_req_drop", 50);
    chk("t6_idle_after_ack", busy, 0);
    repeat (4) @(posedge clk);
    #1;
    queues_empty("t6");

    // 7: reset while a write is pending
    ack_en = 1'b0;
    frame_start();
    send_byte(8'h40, 0);
    send_byte(8'h12, 0);
    chk("t7_we", reg_we, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("t7_we_rst", reg_we, 0);
    chk("t7_busy_rst", busy, 0);
    chk("t7_addr_rst", reg_addr, 0);
    ss = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ack_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("t7_idle_status", tx_byte, 8'h15);
    queues_empty("t7");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    chk("watchdog", 1, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
